// File: rtl/icache_dm_if.sv
// CPU fetch port and Memory port-1 signals of the direct-mapped instruction cache.
// Handshake: CPU holds CPU_RDEN/CPU_ADDR until CPU_VALID; cache holds MEM_RDEN1/MEM_ADDR1 until a memValid1 pulse.
interface icache_dm_if;
   logic        CPU_RDEN;
   logic [13:0] CPU_ADDR;
   logic        FLUSH;
   logic [31:0] CPU_DOUT;
   logic        CPU_VALID;
   logic        CPU_STALL;
   logic        MEM_RDEN1;
   logic [13:0] MEM_ADDR1;
   logic [31:0] MEM_DOUT1;
   logic        memValid1;

   modport slave (
      input  CPU_RDEN, CPU_ADDR, FLUSH, MEM_DOUT1, memValid1,
      output CPU_DOUT, CPU_VALID, CPU_STALL, MEM_RDEN1, MEM_ADDR1
   );

   modport master (
      output CPU_RDEN, CPU_ADDR, FLUSH, MEM_DOUT1, memValid1,
      input  CPU_DOUT, CPU_VALID, CPU_STALL, MEM_RDEN1, MEM_ADDR1
   );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, line-aligned word-by-word refill on a miss.
module icache_dm #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic              CLK,
   input  logic              RST,
   icache_dm_if.slave        bus,
   output logic [1:0]        dbg_state_o
);
   localparam int OW = $clog2(WORDS);
   localparam int IW = $clog2(LINES);
   localparam int TW = 14 - OW - IW;

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     req_tag_q, req_tag_d;
   logic [IW-1:0]     req_idx_q, req_idx_d;
   logic [OW-1:0]     req_off_q, req_off_d;
   logic [OW-1:0]     cnt_q, cnt_d;
   logic              flush_pend_q, flush_pend_d;
   logic [LINES-1:0]  valid_q, valid_d;

   logic [31:0]       data_q [LINES*WORDS];
   logic [TW-1:0]     tag_q  [LINES];

   logic [TW-1:0]     lk_tag;
   logic [IW-1:0]     lk_idx;
   logic [OW-1:0]     lk_off;
   logic              hit;
   logic              last_word;

   assign lk_tag    = bus.CPU_ADDR[13 -: TW];
   assign lk_idx    = bus.CPU_ADDR[OW +: IW];
   assign lk_off    = bus.CPU_ADDR[OW-1:0];
   assign hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign last_word = (cnt_q == OW'(WORDS - 1));

   always_comb begin
      state_d      = state_q;
      req_tag_d    = req_tag_q;
      req_idx_d    = req_idx_q;
      req_off_d    = req_off_q;
      cnt_d        = cnt_q;
      valid_d      = valid_q;
      flush_pend_d = flush_pend_q;
      // A flush arriving mid-miss is deferred so the line being filled is dropped with the rest.
      if (bus.FLUSH && state_q != IDLE) flush_pend_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (bus.FLUSH) valid_d = '0;
            if (bus.CPU_RDEN && !hit) begin
               state_d   = FILL;
               req_tag_d = lk_tag;
               req_idx_d = lk_idx;
               req_off_d = lk_off;
               cnt_d     = '0;
            end
         end
         FILL: begin
            if (bus.memValid1) state_d = last_word ? DONE : GAP;
         end
         GAP: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = FILL;
         end
         DONE: begin
            valid_d[req_idx_q] = 1'b1;
            if (flush_pend_q || bus.FLUSH) valid_d = '0;
            flush_pend_d = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         req_tag_q    <= '0;
         req_idx_q    <= '0;
         req_off_q    <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         req_tag_q    <= req_tag_d;
         req_idx_q    <= req_idx_d;
         req_off_q    <= req_off_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         valid_q      <= valid_d;
      end
   end

   // Storage arrays carry no reset; the valid bits alone decide what is usable.
   always_ff @(posedge CLK) begin
      if (state_q == FILL && bus.memValid1) data_q[{req_idx_q, cnt_q}] <= bus.MEM_DOUT1;
      if (state_q == DONE) tag_q[req_idx_q] <= req_tag_q;
   end

   assign bus.MEM_RDEN1 = (state_q == FILL);
   assign bus.MEM_ADDR1 = {req_tag_q, req_idx_q, cnt_q};
   assign dbg_state_o   = state_q;

   always_comb begin
      bus.CPU_VALID = 1'b0;
      bus.CPU_STALL = 1'b0;
      bus.CPU_DOUT  = '0;
      if (!RST) begin
         case (state_q)
            IDLE: begin
               if (bus.CPU_RDEN) begin
                  if (hit) begin
                     bus.CPU_VALID = 1'b1;
                     bus.CPU_DOUT  = data_q[{lk_idx, lk_off}];
                  end else begin
                     bus.CPU_STALL = 1'b1;
                  end
               end
            end
            FILL, GAP: bus.CPU_STALL = 1'b1;
            DONE: begin
               bus.CPU_VALID = 1'b1;
               bus.CPU_DOUT  = data_q[{req_idx_q, req_off_q}];
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: memory model answering on the 3rd FILL cycle, scoreboard of CPU words and fill addresses.
module tb_icache_dm;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;
   logic [1:0] dcnt;
   logic       mv_inject;
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [13:0] fill_q[$];

   always #5 clk = ~clk;

   icache_dm_if bus();

   icache_dm #(.LINES(16), .WORDS(4)) dut (
      .CLK         (clk),
      .RST         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Memory model: data = 0xA000_0000 | addr, valid in the 3rd consecutive request cycle.
   assign bus.memValid1 = (bus.MEM_RDEN1 && dcnt == 2'd2) || mv_inject;
   assign bus.MEM_DOUT1 = 32'hA000_0000 | {18'd0, bus.MEM_ADDR1};

   always @(posedge clk or posedge rst) begin
      if (rst) dcnt <= 2'd0;
      else if (bus.MEM_RDEN1 && !bus.memValid1) dcnt <= dcnt + 2'd1;
      else dcnt <= 2'd0;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.CPU_VALID) begin
            if (exp_q.size() == 0) check_eq("valid_without_request", 32'(exp_q.size()), 32'd1);
            else check_eq("cpu_dout", bus.CPU_DOUT, exp_q.pop_front());
         end else begin
            check_eq("dout_zero_when_invalid", bus.CPU_DOUT, 32'd0);
         end
         if (bus.MEM_RDEN1 && bus.memValid1) begin
            if (fill_q.size() == 0) check_eq("unexpected_fill", 32'(fill_q.size()), 32'd1);
            else check_eq("fill_addr", {18'd0, bus.MEM_ADDR1}, {18'd0, fill_q.pop_front()});
         end
      end
   end

   task automatic fetch(input logic [13:0] addr, input bit miss);
      int n;
      bit got;
      @(posedge clk); #1;
      bus.CPU_RDEN = 1'b1;
      bus.CPU_ADDR = addr;
      exp_q.push_back(32'hA000_0000 | {18'd0, addr});
      if (miss) for (int w = 0; w < 4; w++) fill_q.push_back({addr[13:2], 2'(w)});
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) check_eq("mem_rden_in_request_cycle", 32'(bus.MEM_RDEN1), 32'd0);
         if (bus.CPU_VALID) begin
            got = 1'b1;
            check_eq("stall_low_at_valid", 32'(bus.CPU_STALL), 32'd0);
         end else begin
            check_eq("stall_while_waiting", 32'(bus.CPU_STALL), 32'd1);
         end
      end
      check_eq(miss ? "miss_latency" : "hit_latency", 32'(n), miss ? 32'd17 : 32'd1);
      @(posedge clk); #1;
      bus.CPU_RDEN = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] a;
      rst           = 1'b1;
      mv_inject     = 1'b0;
      bus.CPU_RDEN  = 1'b0;
      bus.CPU_ADDR  = '0;
      bus.FLUSH     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_state", 32'(dbg_state), 32'd0);
      check_eq("reset_mem_rden", 32'(bus.MEM_RDEN1), 32'd0);
      check_eq("reset_mem_addr", {18'd0, bus.MEM_ADDR1}, 32'd0);
      check_eq("reset_cpu_valid", 32'(bus.CPU_VALID), 32'd0);
      check_eq("reset_cpu_stall", 32'(bus.CPU_STALL), 32'd0);
      check_eq("reset_cpu_dout", bus.CPU_DOUT, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      fetch(14'h0010, 1'b1);   // cold miss
      fetch(14'h0013, 1'b0);   // hit in the filled line
      fetch(14'h0011, 1'b0);

      @(posedge clk); #1; bus.FLUSH = 1'b1;
      @(posedge clk); #1; bus.FLUSH = 1'b0;
      fetch(14'h0010, 1'b1);   // flushed in idle, misses again

      fetch(14'h0050, 1'b1);   // conflict on index 4
      fetch(14'h0010, 1'b1);   // evicted, misses again

      fetch(14'h0122, 1'b1);   // unaligned miss, fill starts at 0x0120
      repeat (4) begin
         a = 14'h0120 | 14'($urandom_range(0, 3));
         fetch(a, 1'b0);
      end

      fork
         fetch(14'h0030, 1'b1);
         begin
            int k = 0;
            @(negedge clk);
            while (!bus.memValid1 && k < 40) begin
               @(negedge clk);
               k++;
            end
            @(posedge clk); #1;
            check_eq("flush_pulse_in_gap", 32'(dbg_state), 32'd2);
            bus.FLUSH = 1'b1;
            @(posedge clk); #1;
            bus.FLUSH = 1'b0;
         end
      join
      fetch(14'h0030, 1'b1);   // pending flush dropped the line

      @(posedge clk); #1;
      bus.CPU_RDEN = 1'b1;
      bus.CPU_ADDR = 14'h0200;
      fill_q.push_back(14'h0200);
      repeat (6) @(negedge clk);
      check_eq("second_fill_rden", 32'(bus.MEM_RDEN1), 32'd1);
      check_eq("second_fill_addr", {18'd0, bus.MEM_ADDR1}, 32'h0201);
      #1 rst = 1'b1;
      #1;
      check_eq("reset_drops_rden", 32'(bus.MEM_RDEN1), 32'd0);
      check_eq("reset_drops_stall", 32'(bus.CPU_STALL), 32'd0);
      check_eq("reset_drops_valid", 32'(bus.CPU_VALID), 32'd0);
      @(posedge clk); #1;
      bus.CPU_RDEN = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mv_inject = 1'b1;
      @(posedge clk); #1;
      mv_inject = 1'b0;
      check_eq("late_mem_valid_ignored", 32'(dbg_state), 32'd0);
      fetch(14'h0200, 1'b1);   // partial line never became valid

      repeat (2) @(posedge clk);
      check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check_eq("fill_q_drained", 32'(fill_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
